// File: rtl/fifo_drain_rr_pkg.sv
// ============================================================================
// fifo_drain_rr_pkg
// Shared constants and state encoding for the output-FIFO drain block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_drain_rr_pkg;

    localparam int NPORT   = 4;
    localparam int PORT_W  = 2;
    localparam int STATE_W = 2;

    // Class field occupies the top CLS_W bits of every word
    localparam int CLS_W   = 2;

    localparam logic [STATE_W-1:0] ST_INIT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fifo_drain_rr_arbiter.sv
// ============================================================================
// rr_arbiter4
// Four-way round-robin pick: first requester at or above the pointer, mod 4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter4
    import fifo_drain_rr_pkg::*;
(
    input  logic [NPORT-1:0]  request,
    input  logic [PORT_W-1:0] pointer,
    output logic [NPORT-1:0]  grant,
    output logic [PORT_W-1:0] grant_idx,
    output logic              grant_vld
);

    logic [PORT_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        grant_idx = pointer;
        grant_vld = 1'b0;
        w_cand    = pointer;
        for (int i = NPORT - 1; i >= 0; i--) begin
            w_cand = pointer + PORT_W'(i);
            if (request[w_cand]) begin
                grant_idx = w_cand;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_drain_rr.sv
// ============================================================================
// fifo_drain_rr
// Round-robin drain of FIFOs 4..7 with per-port saturating counts and class check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_drain_rr
    import fifo_drain_rr_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              ready,
    input  logic [NPORT-1:0]  empty,
    input  logic [DATA_W-1:0] fifo4_out,
    input  logic [DATA_W-1:0] fifo5_out,
    input  logic [DATA_W-1:0] fifo6_out,
    input  logic [DATA_W-1:0] fifo7_out,
    output logic [NPORT-1:0]  pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [PORT_W-1:0] port_out,
    output logic              class_err,
    input  logic              req,
    input  logic [PORT_W-1:0] idx,
    output logic [CNT_W-1:0]  counter_out,
    output logic              counter_vld
);

    localparam int CLS_LSB = DATA_W - CLS_W;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [PORT_W-1:0]  r_ptr;
    logic [NPORT-1:0]   w_grant;
    logic [PORT_W-1:0]  w_gidx;
    logic               w_gvld;
    logic               r_valid;
    logic [PORT_W-1:0]  r_port;
    logic [CNT_W-1:0]   r_cnt [NPORT];
    logic [CNT_W-1:0]   r_cnt_out;
    logic               r_cnt_vld;

    rr_arbiter4 u_arb (
        .request   (~empty),
        .pointer   (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_vld (w_gvld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:  w_next_state = ST_IDLE;
            ST_IDLE:  if (ready && !(&empty)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (!ready || (&empty)) w_next_state = ST_IDLE;
            default:  w_next_state = ST_INIT;
        endcase
        if (init) begin
            w_next_state = ST_INIT;
        end
    end

    // A soft clear in flight also suppresses the pop so nothing escapes uncounted
    always_comb begin
        pop = '0;
        if ((r_state != ST_INIT) && ready && !init && w_gvld) begin
            pop = w_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_port  <= '0;
        end else begin
            r_valid <= |pop;
            if (|pop) begin
                r_ptr  <= w_gidx + PORT_W'(1);
                r_port <= w_gidx;
            end
        end
    end

    // FIFO read data arrives the cycle after its pop, so the word is muxed, not re-registered
    always_comb begin
        data_out = '0;
        if (r_valid) begin
            case (r_port)
                2'd0:    data_out = fifo4_out;
                2'd1:    data_out = fifo5_out;
                2'd2:    data_out = fifo6_out;
                default: data_out = fifo7_out;
            endcase
        end
    end

    assign valid_out = r_valid;
    assign port_out  = r_port;
    assign class_err = r_valid && (data_out[DATA_W-1:CLS_LSB] != r_port);

    generate
        for (genvar p = 0; p < NPORT; p++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt[p] <= '0;
                end else if (init || (r_state == ST_INIT)) begin
                    r_cnt[p] <= '0;
                end else if (pop[p] && (r_cnt[p] != {CNT_W{1'b1}})) begin
                    r_cnt[p] <= r_cnt[p] + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_out <= '0;
            r_cnt_vld <= 1'b0;
        end else begin
            r_cnt_vld <= req;
            if (req) begin
                r_cnt_out <= r_cnt[idx];
            end
        end
    end

    assign counter_out = r_cnt_out;
    assign counter_vld = r_cnt_vld;

endmodule

`default_nettype wire
